// File: rtl/img_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img_stream_pkg
// Brief    : Shared state encoding and stream-entry layout for image_stream_source.
// Revision : 1.0 - initial release
// ============================================================================
package img_stream_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_FETCH = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_GAP   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 3'd4;

    // Entry layout: {pixel, eof, eol, sof}
    localparam int c_MARK_W  = 3;
    localparam int c_SOF_BIT = 0;
    localparam int c_EOL_BIT = 1;
    localparam int c_EOF_BIT = 2;

    function automatic int entry_width(input int pix_w);
        return pix_w + c_MARK_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_skid_fifo
// Brief    : Two-entry synchronous FIFO holding stream entries ahead of the output.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_skid_fifo #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A full FIFO may still accept when the head leaves in the same cycle
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/image_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : image_stream_source
// Brief    : Raster-order pixel source reading a frame from sync-read memory.
// Revision : 1.0 - initial release
// ============================================================================
module image_stream_source
    import img_stream_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 16,
    parameter int PIX_W    = 8,
    parameter int LINE_GAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int c_ENTRY_W  = entry_width(PIX_W);
    localparam int c_COL_W    = $clog2(IMG_W);
    localparam int c_GAP_LAST = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;
    localparam int c_GAP_W    = (c_GAP_LAST > 0) ? $clog2(c_GAP_LAST + 1) : 1;

    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL  = c_COL_W'(IMG_W - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_END   = c_GAP_W'(c_GAP_LAST);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [c_COL_W-1:0]   r_col;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic                 r_inflight;
    logic [c_MARK_W-1:0]  r_inflight_mark;
    logic [c_MARK_W-1:0]  w_issue_mark;
    logic                 w_issue;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_head;
    logic [1:0]           w_count;
    logic                 w_empty;

    assign valid_out = !w_empty;
    assign w_pop     = valid_out && ready_in;

    // Keep FIFO occupancy plus the read in flight at or below two entries
    assign w_issue = (r_state == c_ST_FETCH) &&
                     (({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

    always_comb begin
        w_issue_mark            = '0;
        w_issue_mark[c_SOF_BIT] = (r_addr == '0);
        w_issue_mark[c_EOL_BIT] = (r_col == c_LAST_COL);
        w_issue_mark[c_EOF_BIT] = (r_addr == c_LAST_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_col           <= '0;
            r_addr          <= '0;
            r_gap_cnt       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_mark <= '0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_mark <= w_issue_mark;
            end
            if (r_state == c_ST_IDLE && start) begin
                r_col  <= '0;
                r_addr <= '0;
            end else if (w_issue) begin
                r_col <= (r_col == c_LAST_COL) ? '0 : r_col + c_COL_W'(1);
                if (r_addr != c_LAST_ADDR) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            r_gap_cnt <= (r_state == c_ST_GAP) ? r_gap_cnt + c_GAP_W'(1) : '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_next_state = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (w_issue) begin
                    if (r_addr == c_LAST_ADDR) begin
                        w_next_state = c_ST_DRAIN;
                    end else if ((r_col == c_LAST_COL) && (LINE_GAP > 0)) begin
                        w_next_state = c_ST_GAP;
                    end
                end
            end
            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_END) w_next_state = c_ST_FETCH;
            end
            c_ST_DRAIN: begin
                // The eof entry is the last one pushed, so its transfer empties everything
                if (!r_inflight && w_pop && w_head[c_EOF_BIT]) w_next_state = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    pixel_skid_fifo #(
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data ({mem_data, r_inflight_mark}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? r_addr : '0;
    assign pixel_out = valid_out ? w_head[c_MARK_W +: PIX_W] : '0;
    assign sof       = valid_out && w_head[c_SOF_BIT];
    assign eol       = valid_out && w_head[c_EOL_BIT];
    assign eof       = valid_out && w_head[c_EOF_BIT];
    assign busy      = (r_state == c_ST_FETCH) || (r_state == c_ST_GAP) || (r_state == c_ST_DRAIN);
    assign done      = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
